lfsr_rr_server: RTL and testbench
=================================

Name: lfsr_rr_server

Overview:
Shares one 8-bit Fibonacci LFSR between NUM_REQ requesters.
- Round-robin arbiter picks one pending requester and issues a one-cycle grant. The grant carries the current LFSR value.
- The LFSR advances only when a value is consumed, so every requester gets a distinct, ordered slice of the sequence.
- Sits between the random-number consumers and the LFSR datapath. Also owns runtime reseeding.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEED, 8'h8A, LFSR value after reset. Also the substitute value when a zero seed is loaded.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request, one bit per requester.
- gnt  output  NUM_REQ  one-hot grant pulse; all zero when idle.
- rnd_data  output  8  current LFSR state; valid for the granted requester while gnt is non-zero.
- seed_load  input  1  load seed_val into the LFSR.
- seed_val  input  8  new seed.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, reset_n=0) forces:
  - state=IDLE, gnt=0, busy=0
  - lfsr=SEED, so rnd_data=SEED
  - last_winner=NUM_REQ-1, so the first search starts at requester 0.
- LFSR step:
  - next = {q[6:0], q[1]^q[4]^q[6]^q[7]}
  - Sequence from 8'h8A: 8A, 14, 29, 52, A5, ...
- FSM has two states:
  - IDLE: if seed_load=0 and req!=0, pick the first set req bit scanning from last_winner+1 upward with wrap, latch it into winner_q, go to ISSUE. If seed_load=1, load the LFSR, stay in IDLE and do no arbitration that cycle. If req=0, stay in IDLE.
  - ISSUE: gnt=onehot(winner_q) for exactly this cycle and busy=1. At the clock edge ending ISSUE: LFSR steps, last_winner<=winner_q, state goes to IDLE.
- Outputs are registered state decodes with no combinational input-to-output path.
- Latency: req sampled in IDLE, gnt in the following cycle.
- Throughput: at most one grant every 2 cycles.
- req is a level:
  - A requester holding req high receives repeated grants in round-robin turn.
  - Requester drops req on the cycle after it sees gnt to take one value.
  - req is not re-checked in ISSUE: a withdrawn req still receives the already-scheduled grant.
- Seed load:
  - The LFSR loads seed_val, or SEED if seed_val==8'h00, because all-zero is a lock-up state.
  - In ISSUE, the grant completes with the old value; the load replaces the step at the end of ISSUE.
  - last_winner is unaffected by a seed load.
- Fairness: with all requesters asserting continuously, each is granted once per NUM_REQ grants.
- Reset mid-ISSUE: gnt drops immediately (async) and the LFSR returns to SEED.

Optional Feature:
- Macro LFSR_GRANT_COUNT_EN.
- When defined:
  - Adds output grant_cnt [15:0], which increments by 1 at the end of every ISSUE and wraps 16'hFFFF to 0.
  - Reset value 0.
  - Not cleared by seed_load.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg holds:
  - state typedef {IDLE, ISSUE}
  - LFSR_WIDTH=8
  - tap constant 8'b1101_0010 (bits 7,6,4,1)
  - function lfsr_next(q)
  - default SEED 8'h8A
- One sub-module, lfsr_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req, last_winner. Outputs: winner index, any_req.
  - Reusable by other shared-resource arbiters.
- LFSR register and FSM stay in the top.

Test Plan:
- Reset release with req=0001 held: gnt=0001 with rnd_data=8A, then 14, then 29, one grant every 2 cycles; busy toggles 1/0.
- req=1111 held from reset: grant order 0,1,2,3,0 with rnd_data 8A,14,29,52,A5.
- req=0101 held, then req[1] raised mid-run: no requester is starved; after req[1] rises, grants visit 0, 1 and 2 in rotation.
- seed_load with seed_val=8'h00 in IDLE: rnd_data=8A next cycle, no grant that cycle; seed_val=8'h29 with req pending gives a later grant carrying 29, next 52.
- seed_load=1 with seed_val=8'h52 during ISSUE: grant carries the old value; next grant carries 52, not the stepped value.
- reset_n pulsed low during ISSUE: gnt=0 immediately, rnd_data=8A. With LFSR_GRANT_COUNT_EN, grant_cnt=0 after reset and equals 5 after five grants.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR round-robin server: FSM state type,
// LFSR geometry, feedback taps, default seed and the step function.
package lfsr_pkg;

   localparam int unsigned LFSR_WIDTH = 8;

   // Feedback taps at bits 7, 6, 4 and 1.
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'b1101_0010;

   localparam logic [LFSR_WIDTH-1:0] SEED_DEFAULT = 8'h8A;

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   // One Fibonacci step: shift left and insert the XOR of the tapped bits.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] q);
      return {q[LFSR_WIDTH-2:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after last_winner+1 (with wrap) and whether any request is pending.
module lfsr_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_winner_i,
   output logic [IDX_W-1:0]   winner_o,
   output logic               any_req_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // Scan NUM_REQ candidates starting just after the previous winner.
   always_comb begin
      winner_o  = last_winner_i;
      any_req_o = |req_i;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((32'(last_winner_i) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            winner_o = cand;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lfsr_rr_server.sv
// Shares one 8-bit Fibonacci LFSR between NUM_REQ requesters through a
// round-robin arbiter; the LFSR advances only when a grant consumes a value.
// Optional feature macro: LFSR_GRANT_COUNT_EN adds a 16-bit grant counter.
module lfsr_rr_server
   import lfsr_pkg::*;
#(
   parameter int unsigned            NUM_REQ = 4,
   parameter logic [LFSR_WIDTH-1:0]  SEED    = SEED_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [LFSR_WIDTH-1:0] rnd_data,
   input  logic                  seed_load,
   input  logic [LFSR_WIDTH-1:0] seed_val,
   output logic                  busy
`ifdef LFSR_GRANT_COUNT_EN
   ,
   output logic [15:0]           grant_cnt
`endif
);

   localparam int unsigned      IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

   state_t                  state_q;
   logic [IDX_W-1:0]        winner_q;
   logic [IDX_W-1:0]        last_winner_q;
   logic [LFSR_WIDTH-1:0]   lfsr_q;
   logic [NUM_REQ-1:0]      gnt_q;
   logic                    busy_q;

   logic [IDX_W-1:0]        pick_idx;
   logic                    any_req;
   logic [NUM_REQ-1:0]      onehot_d;
   logic [LFSR_WIDTH-1:0]   seed_d;
   logic [LFSR_WIDTH-1:0]   step_d;

   lfsr_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i         (req),
      .last_winner_i (last_winner_q),
      .winner_o      (pick_idx),
      .any_req_o     (any_req)
   );

   // Next-value candidates: grant one-hot, zero-safe seed, and stepped LFSR.
   always_comb begin
      onehot_d = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         onehot_d[i] = (pick_idx == IDX_W'(i));
      end
      seed_d = (seed_val == '0) ? SEED : seed_val;
      step_d = lfsr_next(lfsr_q);
   end

   // Arbitration FSM with registered grant/busy and the shared LFSR.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         winner_q      <= '0;
         last_winner_q <= LAST_RESET;
         lfsr_q        <= SEED;
         gnt_q         <= '0;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (seed_load) begin
                  lfsr_q <= seed_d;
               end else if (any_req) begin
                  winner_q <= pick_idx;
                  gnt_q    <= onehot_d;
                  busy_q   <= 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               // A seed load here replaces the step; the grant already used the old value.
               lfsr_q        <= seed_load ? seed_d : step_d;
               last_winner_q <= winner_q;
               gnt_q         <= '0;
               busy_q        <= 1'b0;
               state_q       <= IDLE;
            end
            default: begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef LFSR_GRANT_COUNT_EN
   logic [15:0] cnt_q;

   // Counts completed grants; wraps naturally and ignores seed loads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (state_q == ISSUE) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign grant_cnt = cnt_q;
`endif

   assign gnt      = gnt_q;
   assign busy     = busy_q;
   assign rnd_data = lfsr_q;

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Directed bench for lfsr_rr_server with hand-computed expectations.
// LFSR sequence from 8A: 8A, 14, 29, 52, A5, 4B.
module tb_lfsr_rr_server;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [7:0] rnd_data;
   logic       seed_load;
   logic [7:0] seed_val;
   logic       busy;
`ifdef LFSR_GRANT_COUNT_EN
   logic [15:0] grant_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   lfsr_rr_server #(
      .NUM_REQ (4),
      .SEED    (8'h8A)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .gnt       (gnt),
      .rnd_data  (rnd_data),
      .seed_load (seed_load),
      .seed_val  (seed_val),
      .busy      (busy)
`ifdef LFSR_GRANT_COUNT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Grant cycle followed by the idle cycle that advances the LFSR.
   task automatic expect_grant(input string tag, input logic [3:0] g, input logic [7:0] v);
      step();
      check({tag, "_gnt"}, 16'(gnt), 16'(g));
      check({tag, "_rnd"}, 16'(rnd_data), 16'(v));
      check({tag, "_busy"}, 16'(busy), 16'd1);
      step();
      check({tag, "_gap_gnt"}, 16'(gnt), 16'd0);
      check({tag, "_gap_busy"}, 16'(busy), 16'd0);
   endtask

   // Called just after a rising edge; releases reset just after a later edge.
   task automatic do_reset(input logic [3:0] r);
      reset_n   = 1'b0;
      seed_load = 1'b0;
      seed_val  = 8'h00;
      req       = r;
      #2;
      check("rst_gnt", 16'(gnt), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_rnd", 16'(rnd_data), 16'h8A);
`ifdef LFSR_GRANT_COUNT_EN
      check("rst_cnt", grant_cnt, 16'd0);
`endif
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      req       = '0;
      seed_load = 1'b0;
      seed_val  = '0;
      step();

      // Single requester: consecutive sequence values, one grant per 2 cycles.
      do_reset(4'b0001);
      expect_grant("single0", 4'b0001, 8'h8A);
      expect_grant("single1", 4'b0001, 8'h14);
      expect_grant("single2", 4'b0001, 8'h29);

      // All requesters: rotation 0,1,2,3,0.
      step();
      do_reset(4'b1111);
      expect_grant("all0", 4'b0001, 8'h8A);
      expect_grant("all1", 4'b0010, 8'h14);
      expect_grant("all2", 4'b0100, 8'h29);
      expect_grant("all3", 4'b1000, 8'h52);
      expect_grant("all4", 4'b0001, 8'hA5);
`ifdef LFSR_GRANT_COUNT_EN
      check("cnt_after5", grant_cnt, 16'd5);
`endif

      // Sparse requesters, then req[1] joins while requester 0 is granted.
      step();
      do_reset(4'b0101);
      expect_grant("sp0", 4'b0001, 8'h8A);
      expect_grant("sp1", 4'b0100, 8'h14);
      step();
      check("sp2_gnt", 16'(gnt), 16'b0001);
      check("sp2_rnd", 16'(rnd_data), 16'h29);
      req = 4'b0111;
      step();
      expect_grant("sp3", 4'b0010, 8'h52);
      expect_grant("sp4", 4'b0100, 8'hA5);
      expect_grant("sp5", 4'b0001, 8'h4B);

      // Seed loads in IDLE: zero seed maps to SEED, loads block arbitration.
      step();
      do_reset(4'b0001);
      step();
      check("sl_g0", 16'(gnt), 16'b0001);
      req = 4'b0000;
      step();
      check("sl_rnd14", 16'(rnd_data), 16'h14);
      req       = 4'b0001;
      seed_load = 1'b1;
      seed_val  = 8'h00;
      step();
      check("sl_zero_rnd", 16'(rnd_data), 16'h8A);
      check("sl_zero_gnt", 16'(gnt), 16'd0);
      check("sl_zero_busy", 16'(busy), 16'd0);
      seed_val = 8'h29;
      step();
      check("sl_29_rnd", 16'(rnd_data), 16'h29);
      check("sl_29_gnt", 16'(gnt), 16'd0);
      seed_load = 1'b0;
      expect_grant("sl_g29", 4'b0001, 8'h29);
      step();
      check("sl_g52_gnt", 16'(gnt), 16'b0001);
      check("sl_g52_rnd", 16'(rnd_data), 16'h52);
      req = 4'b0000;
      step();
      step();
      check("sl_idle_gnt", 16'(gnt), 16'd0);

      // Seed load during ISSUE replaces the step; last_winner still advances.
      step();
      do_reset(4'b1111);
      step();
      check("si_gnt", 16'(gnt), 16'b0001);
      check("si_rnd", 16'(rnd_data), 16'h8A);
      seed_load = 1'b1;
      seed_val  = 8'h52;
      step();
      seed_load = 1'b0;
      check("si_loaded", 16'(rnd_data), 16'h52);
      check("si_gap_gnt", 16'(gnt), 16'd0);
      expect_grant("si_next", 4'b0010, 8'h52);

      // Reset asserted mid-ISSUE clears outputs without a clock edge.
      step();
      do_reset(4'b0011);
      expect_grant("ar0", 4'b0001, 8'h8A);
      step();
      check("ar1_gnt", 16'(gnt), 16'b0010);
      check("ar1_rnd", 16'(rnd_data), 16'h14);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_async_gnt", 16'(gnt), 16'd0);
      check("ar_async_rnd", 16'(rnd_data), 16'h8A);
      check("ar_async_busy", 16'(busy), 16'd0);
`ifdef LFSR_GRANT_COUNT_EN
      check("ar_async_cnt", grant_cnt, 16'd0);
`endif
      step();
      reset_n = 1'b1;
      req     = 4'b0000;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
